axi_reg_slice: RTL and testbench

- Single-clock AXI4 pipeline register stage on all five channels (AW, W, B, AR, R).
- Sits directly upstream of axi_async_fifo on the source clock side, between the CPU/interconnect master port and the CDC FIFO.
- Breaks combinational valid/ready/payload paths so the FIFO's write side sees registered inputs and drives only registered outputs back.
- Per-channel mode selects bypass, full-throughput skid buffer, or light half-throughput register.

---
 rtl/axi_pkg.sv | 70 +++++++
 rtl/axi_skid_buf.sv | 79 +++++++
 rtl/axi_reg_slice.sv | 51 +++++
 tb/tb_axi_reg_slice.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 types and register-slice mode encodings for the source-clock side
// (reg slice and async FIFO).
package axi_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 64;
    localparam int ID_WIDTH   = 4;

    localparam int REG_BYPASS = 0;
    localparam int REG_FULL   = 1;
    localparam int REG_LIGHT  = 2;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_aw_chan_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [DATA_WIDTH/8-1:0] strb;
        logic                    last;
    } axi_w_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        logic [1:0]          resp;
    } axi_b_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
    } axi_ar_chan_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            resp;
        logic                  last;
    } axi_r_chan_t;

    typedef struct packed {
        axi_aw_chan_t aw;
        logic         aw_valid;
        axi_w_chan_t  w;
        logic         w_valid;
        logic         b_ready;
        axi_ar_chan_t ar;
        logic         ar_valid;
        logic         r_ready;
    } axi_req_t;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        axi_b_chan_t  b;
        logic         b_valid;
        logic         ar_ready;
        axi_r_chan_t  r;
        logic         r_valid;
    } axi_resp_t;

endpackage

// File: rtl/axi_skid_buf.sv
// One valid/ready register stage: bypass wires, 2-entry skid buffer (full rate),
// or 1-entry register (half rate).
module axi_skid_buf
    import axi_pkg::*;
#(
    parameter type T    = logic,
    parameter int  MODE = REG_FULL
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    if (MODE == REG_BYPASS) begin : g_bypass
        logic unused_clk;
        assign unused_clk = clk_i & rst_ni;
        assign valid_o    = valid_i;
        assign data_o     = data_i;
        assign ready_o    = ready_i;
    end else if (MODE == REG_FULL) begin : g_full
        logic valid_q, skid_valid_q;
        T     data_q, skid_data_q;
        logic in_fire;

        // ready_o comes straight from a flop so upstream never sees ready_i
        assign in_fire = valid_i & ~skid_valid_q;
        assign ready_o = ~skid_valid_q;
        assign valid_o = valid_q;
        assign data_o  = data_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q      <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (skid_valid_q) begin
                if (ready_i) skid_valid_q <= 1'b0;
            end else if (in_fire && valid_q && !ready_i) begin
                skid_valid_q <= 1'b1;
            end else begin
                valid_q <= in_fire | (valid_q & ~ready_i);
            end
        end

        always_ff @(posedge clk_i) begin
            if (skid_valid_q) begin
                if (ready_i) data_q <= skid_data_q;
            end else if (in_fire) begin
                if (valid_q && !ready_i) skid_data_q <= data_i;
                else                     data_q      <= data_i;
            end
        end
    end else if (MODE == REG_LIGHT) begin : g_light
        logic valid_q;
        T     data_q;

        assign ready_o = ~valid_q;
        assign valid_o = valid_q;
        assign data_o  = data_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)      valid_q <= 1'b0;
            else if (valid_q) begin
                if (ready_i) valid_q <= 1'b0;
            end else if (valid_i) valid_q <= 1'b1;
        end

        always_ff @(posedge clk_i) begin
            if (!valid_q && valid_i) data_q <= data_i;
        end
    end else begin : g_bad_mode
        $error("axi_skid_buf: MODE must be 0, 1 or 2");
    end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one independent axi_skid_buf per channel, placed in front
// of the async FIFO on the source clock.
module axi_reg_slice
    import axi_pkg::*;
#(
    parameter int AW_MODE = REG_FULL,
    parameter int W_MODE  = REG_FULL,
    parameter int B_MODE  = REG_FULL,
    parameter int AR_MODE = REG_FULL,
    parameter int R_MODE  = REG_FULL
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  axi_req_t  s_req_i,
    output axi_resp_t s_resp_o,
    output axi_req_t  m_req_o,
    input  axi_resp_t m_resp_i
);

    axi_skid_buf #(.T(axi_aw_chan_t), .MODE(AW_MODE)) u_aw (
        .clk_i, .rst_ni,
        .valid_i(s_req_i.aw_valid),  .ready_o(s_resp_o.aw_ready), .data_i(s_req_i.aw),
        .valid_o(m_req_o.aw_valid),  .ready_i(m_resp_i.aw_ready), .data_o(m_req_o.aw)
    );

    axi_skid_buf #(.T(axi_w_chan_t), .MODE(W_MODE)) u_w (
        .clk_i, .rst_ni,
        .valid_i(s_req_i.w_valid),   .ready_o(s_resp_o.w_ready),  .data_i(s_req_i.w),
        .valid_o(m_req_o.w_valid),   .ready_i(m_resp_i.w_ready),  .data_o(m_req_o.w)
    );

    axi_skid_buf #(.T(axi_ar_chan_t), .MODE(AR_MODE)) u_ar (
        .clk_i, .rst_ni,
        .valid_i(s_req_i.ar_valid),  .ready_o(s_resp_o.ar_ready), .data_i(s_req_i.ar),
        .valid_o(m_req_o.ar_valid),  .ready_i(m_resp_i.ar_ready), .data_o(m_req_o.ar)
    );

    // Response channels run the other way: the FIFO side is the producer.
    axi_skid_buf #(.T(axi_b_chan_t), .MODE(B_MODE)) u_b (
        .clk_i, .rst_ni,
        .valid_i(m_resp_i.b_valid),  .ready_o(m_req_o.b_ready),   .data_i(m_resp_i.b),
        .valid_o(s_resp_o.b_valid),  .ready_i(s_req_i.b_ready),   .data_o(s_resp_o.b)
    );

    axi_skid_buf #(.T(axi_r_chan_t), .MODE(R_MODE)) u_r (
        .clk_i, .rst_ni,
        .valid_i(m_resp_i.r_valid),  .ready_o(m_req_o.r_ready),   .data_i(m_resp_i.r),
        .valid_o(s_resp_o.r_valid),  .ready_i(s_req_i.r_ready),   .data_o(s_resp_o.r)
    );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice with AW/W/AR full, B bypass, R light; queue-occupancy
// model per channel plus directed literal checks and a random stall phase.
module tb_axi_reg_slice;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_req_t  s_req, m_req;
    axi_resp_t s_resp, m_resp;

    axi_reg_slice #(
        .AW_MODE(REG_FULL), .W_MODE(REG_FULL), .B_MODE(REG_BYPASS),
        .AR_MODE(REG_FULL), .R_MODE(REG_LIGHT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_req_i(s_req), .s_resp_o(s_resp),
        .m_req_o(m_req), .m_resp_i(m_resp)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: a buffered stage is just a FIFO of accepted beats. Full mode holds
    // up to two and accepts while below two; light mode holds one and accepts only when empty.
    axi_aw_chan_t q_aw[$];
    axi_w_chan_t  q_w[$];
    axi_ar_chan_t q_ar[$];
    axi_r_chan_t  q_r[$];

    logic f_aw_in = 0, f_aw_out = 0, f_w_in = 0, f_w_out = 0;
    logic f_ar_in = 0, f_ar_out = 0, f_r_in = 0, f_r_out = 0, f_b = 0;
    axi_aw_chan_t p_aw;
    axi_w_chan_t  p_w;
    axi_ar_chan_t p_ar;
    axi_r_chan_t  p_r;
    int n_aw_out = 0, n_w_out = 0, n_w_last = 0, n_r_in = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("aw_ready", s_resp.aw_ready, q_aw.size() < 2);
            chk("aw_valid", m_req.aw_valid, q_aw.size() != 0);
            if (q_aw.size() != 0) chk("aw_data", m_req.aw, q_aw[0]);
            chk("w_ready", s_resp.w_ready, q_w.size() < 2);
            chk("w_valid", m_req.w_valid, q_w.size() != 0);
            if (q_w.size() != 0) chk("w_data", m_req.w, q_w[0]);
            chk("ar_ready", s_resp.ar_ready, q_ar.size() < 2);
            chk("ar_valid", m_req.ar_valid, q_ar.size() != 0);
            if (q_ar.size() != 0) chk("ar_data", m_req.ar, q_ar[0]);
            chk("r_ready", m_req.r_ready, q_r.size() == 0);
            chk("r_valid", s_resp.r_valid, q_r.size() != 0);
            if (q_r.size() != 0) chk("r_data", s_resp.r, q_r[0]);
            chk("b_valid", s_resp.b_valid, m_resp.b_valid);
            chk("b_data", s_resp.b, m_resp.b);
            chk("b_ready", m_req.b_ready, s_req.b_ready);
            f_aw_in  = s_req.aw_valid && s_resp.aw_ready;  p_aw = s_req.aw;
            f_aw_out = m_req.aw_valid && m_resp.aw_ready;
            f_w_in   = s_req.w_valid && s_resp.w_ready;    p_w  = s_req.w;
            f_w_out  = m_req.w_valid && m_resp.w_ready;
            f_ar_in  = s_req.ar_valid && s_resp.ar_ready;  p_ar = s_req.ar;
            f_ar_out = m_req.ar_valid && m_resp.ar_ready;
            f_r_in   = m_resp.r_valid && m_req.r_ready;    p_r  = m_resp.r;
            f_r_out  = s_resp.r_valid && s_req.r_ready;
            f_b      = m_resp.b_valid && s_req.b_ready;
        end else begin
            {f_aw_in, f_aw_out, f_w_in, f_w_out, f_ar_in, f_ar_out, f_r_in, f_r_out, f_b} = '0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (f_aw_out) begin void'(q_aw.pop_front()); n_aw_out++; end
            if (f_aw_in) q_aw.push_back(p_aw);
            if (f_w_out) begin
                n_w_out++;
                if (q_w[0].last) n_w_last++;
                void'(q_w.pop_front());
            end
            if (f_w_in) q_w.push_back(p_w);
            if (f_ar_out) void'(q_ar.pop_front());
            if (f_ar_in) q_ar.push_back(p_ar);
            if (f_r_out) void'(q_r.pop_front());
            if (f_r_in) begin q_r.push_back(p_r); n_r_in++; end
        end
    end

    always @(negedge rst_n) begin
        q_aw.delete(); q_w.delete(); q_ar.delete(); q_r.delete();
        {f_aw_in, f_aw_out, f_w_in, f_w_out, f_ar_in, f_ar_out, f_r_in, f_r_out, f_b} = '0;
    end

    // Held beats must not change or vanish before the handshake.
    assert property (@(posedge clk) disable iff (!rst_n)
        m_req.aw_valid && !m_resp.aw_ready |=> m_req.aw_valid && $stable(m_req.aw))
        else $error("FAIL stable_aw");
    assert property (@(posedge clk) disable iff (!rst_n)
        m_req.w_valid && !m_resp.w_ready |=> m_req.w_valid && $stable(m_req.w))
        else $error("FAIL stable_w");
    assert property (@(posedge clk) disable iff (!rst_n)
        m_req.ar_valid && !m_resp.ar_ready |=> m_req.ar_valid && $stable(m_req.ar))
        else $error("FAIL stable_ar");
    assert property (@(posedge clk) disable iff (!rst_n)
        s_resp.r_valid && !s_req.r_ready |=> s_resp.r_valid && $stable(s_resp.r))
        else $error("FAIL stable_r");

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int k = 0;
        s_req.aw_valid = 0; s_req.w_valid = 0; s_req.ar_valid = 0;
        m_resp.r_valid = 0; m_resp.b_valid = 0;
        m_resp.aw_ready = 1; m_resp.w_ready = 1; m_resp.ar_ready = 1;
        s_req.r_ready = 1; s_req.b_ready = 1;
        while ((q_aw.size() + q_w.size() + q_ar.size() + q_r.size()) != 0 && k < 20) begin
            step();
            k++;
        end
        chk(nm, k < 20, 1'b1);
    endtask

    logic [127:0] rv;
    int n;

    initial begin
        s_req = '0;
        m_resp = '0;
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        chk("rst_aw_valid", m_req.aw_valid, 1'b0);
        chk("rst_aw_ready", s_resp.aw_ready, 1'b1);
        chk("rst_w_ready", s_resp.w_ready, 1'b1);
        chk("rst_ar_ready", s_resp.ar_ready, 1'b1);
        chk("rst_r_ready", m_req.r_ready, 1'b1);
        chk("rst_r_valid", s_resp.r_valid, 1'b0);
        step();

        // AW full: 16 back-to-back bursts, downstream always ready
        m_resp.aw_ready = 1;
        for (int i = 0; i < 16; i++) begin
            s_req.aw_valid = 1;
            s_req.aw = '{id: 4'(i), addr: 32'h1000 + 32'(i) * 32'h40, len: 8'd0, size: 3'd3, burst: 2'd1};
            if (i == 0) begin
                #1;
                chk("aw_lat_before_edge", m_req.aw_valid, 1'b0);
            end
            chk("aw_stream_ready", s_resp.aw_ready, 1'b1);
            step();
            if (i == 0) begin
                chk("aw_first_valid", m_req.aw_valid, 1'b1);
                chk("aw_first_addr", m_req.aw.addr, 32'h1000);
            end
        end
        s_req.aw_valid = 0;
        step();
        chk("aw_count", n_aw_out, 16);

        // W full with a 3-cycle downstream stall while beat 2 sits at the output
        n = 0;
        for (int k = 0; n < 8 && k < 40; k++) begin
            logic fire;
            s_req.w_valid = 1;
            s_req.w = '{data: 64'hA5A5_0000_0000_0000 | 64'(n), strb: '1, last: (n == 7)};
            m_resp.w_ready = !(k >= 3 && k <= 5);
            if (k == 3) chk("w_ready_skid_filling", s_resp.w_ready, 1'b1);
            if (k == 4) chk("w_ready_skid_full", s_resp.w_ready, 1'b0);
            if (k == 6) chk("w_ready_skid_draining", s_resp.w_ready, 1'b0);
            if (k == 7) chk("w_ready_reopened", s_resp.w_ready, 1'b1);
            fire = s_resp.w_ready;
            step();
            if (fire) n++;
        end
        drain("w_drain");
        chk("w_count", n_w_out, 8);
        chk("w_last_count", n_w_last, 1);

        // R light: continuous source, half-rate acceptance
        begin
            int r0 = n_r_in;
            n = 0;
            s_req.r_ready = 1;
            m_resp.r_valid = 1;
            for (int k = 0; k < 8; k++) begin
                logic fire;
                m_resp.r = '{id: 4'd1, data: 64'hBEEF_0000 + 64'(n), resp: RESP_OKAY, last: (n == 3)};
                if (k < 4) chk("r_ready_toggle", m_req.r_ready, (k % 2) == 0);
                fire = m_req.r_ready;
                step();
                if (fire) n++;
            end
            chk("r_accepted", n, 4);
            chk("r_model_accepted", n_r_in - r0, 4);
        end
        drain("r_drain");

        // B bypass: same-cycle pass-through, ready wired back
        s_req.b_ready = 0;
        m_resp.b_valid = 1;
        m_resp.b = '{id: 4'd3, resp: RESP_OKAY};
        #1;
        chk("b_pass_valid", s_resp.b_valid, 1'b1);
        chk("b_pass_id", s_resp.b.id, 4'd3);
        chk("b_pass_resp", s_resp.b.resp, RESP_OKAY);
        chk("b_ready_low", m_req.b_ready, 1'b0);
        s_req.b_ready = 1;
        #1;
        chk("b_ready_high", m_req.b_ready, 1'b1);
        step();
        m_resp.b_valid = 0;
        #1;
        chk("b_pass_drop", s_resp.b_valid, 1'b0);
        step();

        // AR full: fill both entries, then async reset between edges
        m_resp.ar_ready = 0;
        for (int i = 0; i < 2; i++) begin
            s_req.ar_valid = 1;
            s_req.ar = '{id: 4'(i), addr: 32'h3000 + 32'(i) * 32'h40, len: 8'd0, size: 3'd3, burst: 2'd1};
            step();
        end
        s_req.ar_valid = 0;
        chk("ar_full_ready", s_resp.ar_ready, 1'b0);
        chk("ar_full_valid", m_req.ar_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rst_valid", m_req.ar_valid, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk("ar_post_rst_ready", s_resp.ar_ready, 1'b1);
        m_resp.ar_ready = 1;
        s_req.ar_valid = 1;
        s_req.ar = '{id: 4'd5, addr: 32'h2000, len: 8'd0, size: 3'd3, burst: 2'd1};
        step();
        s_req.ar_valid = 0;
        chk("ar_new_valid", m_req.ar_valid, 1'b1);
        chk("ar_new_addr", m_req.ar.addr, 32'h2000);
        step();
        chk("ar_new_alone", m_req.ar_valid, 1'b0);

        // Random stalls on every channel; valid holds until accepted
        for (int c = 0; c < 10000; c++) begin
            if (!s_req.aw_valid || f_aw_in) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                s_req.aw_valid = 1'($urandom_range(0, 1));
                s_req.aw = rv[$bits(axi_aw_chan_t)-1:0];
            end
            if (!s_req.w_valid || f_w_in) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                s_req.w_valid = 1'($urandom_range(0, 1));
                s_req.w = rv[$bits(axi_w_chan_t)-1:0];
            end
            if (!s_req.ar_valid || f_ar_in) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                s_req.ar_valid = 1'($urandom_range(0, 1));
                s_req.ar = rv[$bits(axi_ar_chan_t)-1:0];
            end
            if (!m_resp.r_valid || f_r_in) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                m_resp.r_valid = 1'($urandom_range(0, 1));
                m_resp.r = rv[$bits(axi_r_chan_t)-1:0];
            end
            if (!m_resp.b_valid || f_b) begin
                rv = {$urandom, $urandom, $urandom, $urandom};
                m_resp.b_valid = 1'($urandom_range(0, 1));
                m_resp.b = rv[$bits(axi_b_chan_t)-1:0];
            end
            m_resp.aw_ready = ($urandom_range(0, 3) != 0);
            m_resp.w_ready  = ($urandom_range(0, 2) != 0);
            m_resp.ar_ready = 1'($urandom_range(0, 1));
            s_req.r_ready   = ($urandom_range(0, 3) != 0);
            s_req.b_ready   = 1'($urandom_range(0, 1));
            step();
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
